// File: rtl/pcb_pkg.sv
// Shared types and default widths for the pattern count buffer.
// Optional feature macro used by the top: PCB_INDEX_TAG_EN.
package pcb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2,
        READ = 2'd3
    } state_t;

    localparam int STATE_W         = 2;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_CH          = 1;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pcb_edge_sync.sv
// Synchronises the asynchronous DMD sync line and produces single-cycle
// rise/fall pulses from the synchronised level.
module pcb_edge_sync
    import pcb_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign fall = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/pattern_count_buffer.sv
// Per-pattern multi-channel count capture with valid/ready frame readout.
// Define PCB_INDEX_TAG_EN to prefix each readout word with its pattern index.
module pattern_count_buffer
    import pcb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CH          = DEF_CH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
`ifdef PCB_INDEX_TAG_EN
    localparam int RD_W       = ADDR_W + DATA_W
`else
    localparam int RD_W       = DATA_W
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dmd_sig,
    input  logic [CH*DATA_W-1:0] count_in,
    input  logic [ADDR_W:0]      n_patterns,
    input  logic                 arm,
    input  logic                 clear,
    input  logic                 rd_start,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [RD_W-1:0]      rd_data,
    output logic [STATE_W-1:0]   state_o,
    output logic [ADDR_W:0]      wr_count,
    output logic                 overflow,
    output logic                 missed,
    output logic                 frame_done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int TOT_W = $clog2(DEPTH * CH + 1);

    state_t              state, state_nxt;
    logic                rise, fall;
    logic [CNT_W-1:0]    n_lat, n_eff;
    logic [ADDR_W-1:0]   wr_ptr;
    logic                pending;
    logic                frame_full;
    logic [TOT_W-1:0]    total, issued, accepted;
    logic [ADDR_W-1:0]   rd_slot;
    logic [CH_W-1:0]     rd_ch, s1_ch;
    logic                s1_vld;
    logic                out_en, s1_en, issue, accept, last_accept;
    logic [DATA_W-1:0]   sel;
    logic [RD_W-1:0]     rd_word;
    logic [CH*DATA_W-1:0] mem [DEPTH];
    logic [CH*DATA_W-1:0] mem_q;
`ifdef PCB_INDEX_TAG_EN
    logic [ADDR_W-1:0]   s1_idx;
`endif

    pcb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (dmd_sig),
        .rise (rise),
        .fall (fall)
    );

    assign n_eff = (n_patterns == '0 || n_patterns > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n_patterns;
    // frame_full also guards the cycle where ACQ is about to leave for DONE
    assign frame_full  = (wr_count == n_lat);
    assign total       = TOT_W'(int'(n_lat) * CH);
    assign out_en      = !rd_valid || rd_ready;
    assign s1_en       = !s1_vld || out_en;
    assign issue       = (state == READ) && (issued != total) && s1_en;
    assign accept      = rd_valid && rd_ready;
    assign last_accept = accept && (accepted == total - TOT_W'(1));
    assign state_o     = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm)         state_nxt = ACQ;
            ACQ:     if (frame_full)  state_nxt = DONE;
            DONE:    if (rd_start)    state_nxt = READ;
            READ:    if (last_accept) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_comb begin
        sel = '0;
        for (int c = 0; c < CH; c++)
            if (s1_ch == CH_W'(c)) sel = mem_q[c*DATA_W +: DATA_W];
`ifdef PCB_INDEX_TAG_EN
        rd_word = {s1_idx, sel};
`else
        rd_word = sel;
`endif
    end

    // Storage: one wide entry per pattern, read registered into mem_q
    always_ff @(posedge clk) begin
        if (state == ACQ && !frame_full && rise) mem[wr_ptr] <= count_in;
        if (issue) mem_q <= mem[rd_slot];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_lat      <= '0;
            wr_ptr     <= '0;
            wr_count   <= '0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            missed     <= 1'b0;
            frame_done <= 1'b0;
            rd_slot    <= '0;
            rd_ch      <= '0;
            issued     <= '0;
            accepted   <= '0;
            s1_vld     <= 1'b0;
            s1_ch      <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
`ifdef PCB_INDEX_TAG_EN
            s1_idx     <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (clear) begin
                wr_ptr     <= '0;
                wr_count   <= '0;
                pending    <= 1'b0;
                overflow   <= 1'b0;
                missed     <= 1'b0;
                frame_done <= 1'b0;
                rd_slot    <= '0;
                rd_ch      <= '0;
                issued     <= '0;
                accepted   <= '0;
                s1_vld     <= 1'b0;
                rd_valid   <= 1'b0;
            end else begin
                frame_done <= last_accept;
                if (state == IDLE && arm) begin
                    n_lat    <= n_eff;
                    wr_ptr   <= '0;
                    wr_count <= '0;
                    pending  <= 1'b0;
                    overflow <= 1'b0;
                    missed   <= 1'b0;
                end
                if (state == ACQ) begin
                    if (rise) begin
                        if (frame_full) overflow <= 1'b1;
                        else begin
                            pending <= 1'b1;
                            if (pending) missed <= 1'b1;
                        end
                    end else if (fall && !frame_full) begin
                        if (pending) begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            wr_count <= wr_count + 1'b1;
                            pending  <= 1'b0;
                        end else missed <= 1'b1;
                    end
                end
                if ((state == DONE || state == READ) && rise) overflow <= 1'b1;
                if (state == DONE && rd_start) begin
                    rd_slot  <= '0;
                    rd_ch    <= '0;
                    issued   <= '0;
                    accepted <= '0;
                end
                // Two-stage read pipe: RAM output stage, then held output register
                if (s1_en) begin
                    s1_vld <= issue;
                    if (issue) begin
                        s1_ch  <= rd_ch;
`ifdef PCB_INDEX_TAG_EN
                        s1_idx <= rd_slot;
`endif
                        issued <= issued + 1'b1;
                        if (rd_ch == CH_W'(CH - 1)) begin
                            rd_ch   <= '0;
                            rd_slot <= rd_slot + 1'b1;
                        end else rd_ch <= rd_ch + 1'b1;
                    end
                end
                if (out_en) begin
                    rd_valid <= s1_vld;
                    if (s1_vld) rd_data <= rd_word;
                end
                if (accept) accepted <= accepted + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_count_buffer.sv
// Directed sequence with random counts/ready, checked against an array model
// of captured frames; works with or without PCB_INDEX_TAG_EN.
module tb_pattern_count_buffer;

    localparam int DATA_W = 16, CH = 2, DEPTH = 8, ADDR_W = 3, SYNC_STAGES = 2;
`ifdef PCB_INDEX_TAG_EN
    localparam int RD_W = ADDR_W + DATA_W;
`else
    localparam int RD_W = DATA_W;
`endif
    localparam logic [1:0] S_IDLE = 2'd0, S_ACQ = 2'd1, S_DONE = 2'd2;

    logic                 clk = 1'b0, rst_n = 1'b0, dmd_sig = 1'b0;
    logic [CH*DATA_W-1:0] count_in = '0;
    logic [ADDR_W:0]      n_patterns = '0;
    logic                 arm = 1'b0, clear = 1'b0, rd_start = 1'b0, rd_ready = 1'b0;
    logic                 rd_valid, overflow, missed, frame_done;
    logic [RD_W-1:0]      rd_data;
    logic [1:0]           state_o;
    logic [ADDR_W:0]      wr_count;

    int checks = 0, errors = 0;
    logic [DATA_W-1:0] model_mem [DEPTH][CH];
    int model_n = 0;

    pattern_count_buffer #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                           .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .dmd_sig(dmd_sig), .count_in(count_in),
        .n_patterns(n_patterns), .arm(arm), .clear(clear), .rd_start(rd_start),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .state_o(state_o),
        .wr_count(wr_count), .overflow(overflow), .missed(missed), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean DMD pattern; record=1 when the model says the sample is stored
    task automatic pulse(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1, input bit record);
        count_in = {c1, c0};
        dmd_sig = 1'b1;
        step(6);
        dmd_sig = 1'b0;
        step(6);
        if (record) begin
            model_mem[model_n][0] = c0;
            model_mem[model_n][1] = c1;
            model_n++;
        end
    endtask

    task automatic arm_frame(input int n);
        n_patterns = (ADDR_W+1)'(n);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        model_n = 0;
    endtask

    function automatic logic [RD_W-1:0] exp_word(input int k);
        logic [DATA_W-1:0] v;
        v = model_mem[k / CH][k % CH];
`ifdef PCB_INDEX_TAG_EN
        return {ADDR_W'(k / CH), v};
`else
        return v;
`endif
    endfunction

    task automatic read_frame(input bit rand_ready, input string tag);
        int got, fd, budget, first;
        bit stalled, rdy;
        logic [RD_W-1:0] held;
        got = 0; fd = 0; budget = 0; first = -1; stalled = 0; held = '0;
        rd_start = 1'b1;
        step(1);
        rd_start = 1'b0;
        while (got < model_n * CH && budget < 400) begin
            if (rd_valid && first < 0) first = budget;
            if (stalled) begin
                check({tag, "_hold_valid"}, rd_valid, 1'b1);
                check({tag, "_hold_data"}, rd_data, held);
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                check({tag, "_word"}, rd_data, exp_word(got));
                got++;
            end
            stalled = rd_valid && !rdy;
            held = rd_data;
            step(1);
            budget++;
            if (frame_done) fd++;
        end
        rd_ready = 1'b0;
        repeat (3) begin
            step(1);
            if (frame_done) fd++;
        end
        check({tag, "_latency"}, first, 2);
        check({tag, "_count"}, got, model_n * CH);
        check({tag, "_frame_done"}, fd, 1);
        check({tag, "_idle"}, state_o, S_IDLE);
        check({tag, "_valid_off"}, rd_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_state", state_o, S_IDLE);
        check("rst_wr_count", wr_count, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_flags", {overflow, missed, frame_done}, 0);
        rst_n = 1'b1;
        step(2);

        // Basic frame with the documented count pattern
        arm_frame(4);
        check("t1_acq", state_o, S_ACQ);
        for (int i = 0; i < 4; i++) pulse(DATA_W'(16'hA0 + i), DATA_W'(16'hB0 + i), 1);
        check("t1_done", state_o, S_DONE);
        check("t1_wr_count", wr_count, 4);
        read_frame(0, "t1");

        // Random counts, random backpressure
        arm_frame(4);
        for (int i = 0; i < 4; i++) pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        read_frame(1, "t2");

        // Extra pattern after the frame completes
        arm_frame(3);
        for (int i = 0; i < 3; i++) pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        check("t3_done", state_o, S_DONE);
        check("t3_ovf_before", overflow, 0);
        pulse(DATA_W'($urandom), DATA_W'($urandom), 0);
        check("t3_ovf", overflow, 1);
        check("t3_still_done", state_o, S_DONE);
        check("t3_wr_count", wr_count, 3);
        read_frame(1, "t3");
        check("t3_ovf_sticky", overflow, 1);
        arm_frame(2);
        check("t3_arm_clears_ovf", overflow, 0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t3_clear_idle", state_o, S_IDLE);

        // Fall with no captured rise: sync already high when armed
        dmd_sig = 1'b1;
        step(6);
        arm_frame(2);
        dmd_sig = 1'b0;
        step(6);
        check("t4_missed", missed, 1);
        check("t4_no_advance", wr_count, 0);
        pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        check("t4_advance_one", wr_count, 1);
        check("t4_missed_sticky", missed, 1);
        pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        read_frame(0, "t4");

        // Abort mid-readout
        arm_frame(3);
        check("t5_arm_clears_missed", missed, 0);
        for (int i = 0; i < 3; i++) pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        rd_start = 1'b1;
        step(1);
        rd_start = 1'b0;
        rd_ready = 1'b1;
        step(4);
        check("t5_valid_mid", rd_valid, 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        rd_ready = 1'b0;
        check("t5_clear_valid", rd_valid, 0);
        check("t5_clear_idle", state_o, S_IDLE);

        // n_patterns=0 means the full memory depth
        arm_frame(0);
        for (int i = 0; i < DEPTH; i++) pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        check("t6_wr_count", wr_count, DEPTH);
        check("t6_done", state_o, S_DONE);
        read_frame(1, "t6");

        // Async reset while acquiring, checked before any clock edge
        arm_frame(2);
        pulse(DATA_W'($urandom), DATA_W'($urandom), 1);
        check("t7_pre_count", wr_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_state", state_o, S_IDLE);
        check("t7_async_count", wr_count, 0);
        check("t7_async_flags", {rd_valid, overflow, missed, frame_done}, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
